// File: rtl/assist_pkg.sv
// Shared constants for the assist target pipeline: assist-level encoding,
// incline clamp bounds, cadence threshold and default torque deadband.
package assist_pkg;

  // Assist level encoding; level value doubles as the torque gain.
  localparam logic [1:0] ASSIST_OFF  = 2'd0;
  localparam logic [1:0] ASSIST_LOW  = 2'd1;
  localparam logic [1:0] ASSIST_MED  = 2'd2;
  localparam logic [1:0] ASSIST_HIGH = 2'd3;

  // Incline is first saturated to signed 10 bits, then offset into [0, 511].
  localparam int INCL_SAT_MIN = -512;
  localparam int INCL_SAT_MAX = 511;
  localparam int INCL_OFFSET  = 256;
  localparam int INCL_LIM_MAX = 511;

  // Cadence at or below this value counts as "not pedalling".
  localparam int CAD_THRESH = 1;

  // Torque below this offset is sensor noise / rider resting weight.
  localparam logic [11:0] TORQUE_MIN_DEF = 12'h380;

endpackage

// File: rtl/assist_target_pipe_slew_limiter.sv
// Output slew-rate limiter for the assist target current.
// Optional feature macro: BRAKE_CUT_EN adds brake_n, which forces the target
// to zero on the next clock edge and bypasses the slew logic.
module slew_limiter #(
  parameter int          CURR_W  = 12,
  parameter int unsigned SLEW_UP = 'h100,
  parameter int unsigned SLEW_DN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic [CURR_W-1:0] demand,
`ifdef BRAKE_CUT_EN
  input  logic              brake_n,
`endif
  output logic [CURR_W-1:0] target
);

  logic [CURR_W-1:0] target_next;
  logic [CURR_W:0]   diff_up;
  logic [CURR_W:0]   diff_dn;

  // Limit a step magnitude to the configured slew bound.
  function automatic logic [CURR_W:0] clamp_step(input logic [CURR_W:0] d,
                                                 input int unsigned   lim);
    if (32'(d) > lim) return (CURR_W+1)'(lim);
    return d;
  endfunction

  // Add with one carry bit; saturate at all-ones instead of wrapping.
  function automatic logic [CURR_W-1:0] sat_add(input logic [CURR_W-1:0] t,
                                                input logic [CURR_W:0]   s);
    logic [CURR_W:0] sum;
    sum = {1'b0, t} + s;
    return sum[CURR_W] ? '1 : sum[CURR_W-1:0];
  endfunction

  // Subtract with one borrow bit; saturate at zero instead of wrapping.
  function automatic logic [CURR_W-1:0] sat_sub(input logic [CURR_W-1:0] t,
                                                input logic [CURR_W:0]   s);
    logic [CURR_W:0] dif;
    dif = {1'b0, t} - s;
    return dif[CURR_W] ? '0 : dif[CURR_W-1:0];
  endfunction

  // Next target: move toward demand, bounded by SLEW_UP / SLEW_DN.
  always_comb begin
    target_next = target;
    diff_up     = {1'b0, demand} - {1'b0, target};
    diff_dn     = {1'b0, target} - {1'b0, demand};
    if (demand > target) begin
      target_next = sat_add(target, clamp_step(diff_up, SLEW_UP));
    end else if (demand < target) begin
      if (SLEW_DN == 0) target_next = demand;
      else              target_next = sat_sub(target, clamp_step(diff_dn, SLEW_DN));
    end
  end

  // Stage 4 register: update once per valid sample (brake overrides).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
`ifdef BRAKE_CUT_EN
    end else if (!brake_n) begin
      target <= '0;
`endif
    end else if (vld) begin
      target <= target_next;
    end
  end

endmodule

// File: rtl/assist_target_pipe.sv
// Assist target pipeline: turns averaged torque, cadence, incline and assist
// level into a slew-limited motor target current through four stages
// (conditioning, partial products, product/saturate, slew).
// Optional feature macro: BRAKE_CUT_EN (adds brake_n, forces target to 0).
module assist_target_pipe
  import assist_pkg::*;
#(
  parameter int                   TORQUE_W   = 12,
  parameter int                   INCLINE_W  = 13,
  parameter int                   CAD_W      = 5,
  parameter int                   CURR_W     = 12,
  parameter logic [TORQUE_W-1:0]  TORQUE_MIN = TORQUE_W'(TORQUE_MIN_DEF),
  parameter int                   PROD_SHIFT = 14,
  parameter int unsigned          SLEW_UP    = 'h100,
  parameter int unsigned          SLEW_DN    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_vld,
  input  logic        [TORQUE_W-1:0]  avg_torque,
  input  logic        [CAD_W-1:0]     cadence_vec,
  input  logic signed [INCLINE_W-1:0] incline,
  input  logic        [1:0]           setting,
`ifdef BRAKE_CUT_EN
  input  logic                        brake_n,
`endif
  output logic        [CURR_W-1:0]    demand,
  output logic        [CURR_W-1:0]    target_curr,
  output logic                        out_vld
);

  localparam int A1_W   = TORQUE_W + 2;
  localparam int A2_W   = 9 + CAD_W + 1;
  localparam int PROD_W = A1_W + A2_W;
  localparam int SAT_W  = PROD_W + CURR_W;

  logic [TORQUE_W-1:0] torque_pos_p1;
  logic [8:0]          incline_lim_p1;
  logic [CAD_W:0]      cad_factor_p1;
  logic [1:0]          setting_p1;
  logic                vld_p1;

  logic [A1_W-1:0]     a1_p2;
  logic [A2_W-1:0]     a2_p2;
  logic                vld_p2;

  logic [PROD_W-1:0]   prod;
  logic                vld_p3;

  // Torque above the deadband, floored at zero via the borrow bit.
  function automatic logic [TORQUE_W-1:0] torque_floor(input logic [TORQUE_W-1:0] t);
    logic [TORQUE_W:0] d;
    d = {1'b0, t} - {1'b0, TORQUE_MIN};
    return d[TORQUE_W] ? '0 : d[TORQUE_W-1:0];
  endfunction

  // Saturate incline to signed 10 bits, offset it, clamp to [0, 511].
  function automatic logic [8:0] incline_limit(input logic signed [INCLINE_W-1:0] v);
    int s;
    s = 32'(v);
    if (s < INCL_SAT_MIN)      s = INCL_SAT_MIN;
    else if (s > INCL_SAT_MAX) s = INCL_SAT_MAX;
    s = s + INCL_OFFSET;
    if (s < 0)                 s = 0;
    else if (s > INCL_LIM_MAX) s = INCL_LIM_MAX;
    return 9'(s);
  endfunction

  // Cadence factor: zero when not pedalling, otherwise cadence + 2^CAD_W.
  function automatic logic [CAD_W:0] cad_scale(input logic [CAD_W-1:0] c);
    return (32'(c) <= CAD_THRESH) ? '0 : {1'b1, c};
  endfunction

  // Scale the product down; any bit above the output window saturates.
  function automatic logic [CURR_W-1:0] demand_sat(input logic [PROD_W-1:0] p);
    logic [SAT_W-1:0] ext;
    ext = SAT_W'(p);
    if ((ext >> (PROD_SHIFT + CURR_W)) != '0) return '1;
    ext = ext >> PROD_SHIFT;
    return ext[CURR_W-1:0];
  endfunction

  assign prod = PROD_W'(a1_p2) * PROD_W'(a2_p2);

  // Valid shift chain; always advances so the pipe never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      vld_p1  <= in_vld;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      out_vld <= vld_p3;
    end
  end

  // ---- Stage 1: input conditioning ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      torque_pos_p1  <= '0;
      incline_lim_p1 <= '0;
      cad_factor_p1  <= '0;
      setting_p1     <= ASSIST_OFF;
    end else if (in_vld) begin
      torque_pos_p1  <= torque_floor(avg_torque);
      incline_lim_p1 <= incline_limit(incline);
      cad_factor_p1  <= cad_scale(cadence_vec);
      setting_p1     <= setting;
    end
  end

  // ---- Stage 2: full-width partial products ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_p2 <= '0;
      a2_p2 <= '0;
    end else if (vld_p1) begin
      a1_p2 <= A1_W'(torque_pos_p1) * A1_W'(setting_p1);
      a2_p2 <= A2_W'(incline_lim_p1) * A2_W'(cad_factor_p1);
    end
  end

  // ---- Stage 3: final product, scale and saturate to demand ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      demand <= '0;
    end else if (vld_p2) begin
      demand <= demand_sat(prod);
    end
  end

  // ---- Stage 4: slew-limited target ----
  slew_limiter #(
    .CURR_W  (CURR_W),
    .SLEW_UP (SLEW_UP),
    .SLEW_DN (SLEW_DN)
  ) u_slew (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (vld_p3),
    .demand  (demand),
`ifdef BRAKE_CUT_EN
    .brake_n (brake_n),
`endif
    .target  (target_curr)
  );

endmodule

// File: tb/tb_assist_target_pipe.sv
// Testbench for assist_target_pipe (default parameters). Optional feature
// macro BRAKE_CUT_EN enables the brake scenario.
module tb_assist_target_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_vld;
  logic        [11:0] avg_torque;
  logic        [4:0]  cadence_vec;
  logic signed [12:0] incline;
  logic        [1:0]  setting;
`ifdef BRAKE_CUT_EN
  logic               brake_n;
`endif
  logic        [11:0] demand;
  logic        [11:0] target_curr;
  logic               out_vld;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {int due; int val;} ent_t;
  ent_t dq[$];
  ent_t oq[$];
  int   m_dem = 0;
  int   m_tgt = 0;
  bit   m_vld = 1'b0;

  always #5 clk = ~clk;

  assist_target_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vld      (in_vld),
    .avg_torque  (avg_torque),
    .cadence_vec (cadence_vec),
    .incline     (incline),
    .setting     (setting),
`ifdef BRAKE_CUT_EN
    .brake_n     (brake_n),
`endif
    .demand      (demand),
    .target_curr (target_curr),
    .out_vld     (out_vld)
  );

  // Reference demand from the plain arithmetic definition.
  function automatic int ref_demand(int t, int c, int i, int s);
    longint tp, ic, cf, p;
    tp = t - 'h380;
    if (tp < 0) tp = 0;
    ic = i;
    if (ic < -512) ic = -512;
    if (ic > 511)  ic = 511;
    ic = ic + 256;
    if (ic < 0)   ic = 0;
    if (ic > 511) ic = 511;
    cf = (c <= 1) ? 0 : c + 32;
    p  = (tp * s * ic * cf) >> 14;
    return (p > 4095) ? 4095 : int'(p);
  endfunction

  // Reference slew: rise by at most 0x100, drop immediately.
  function automatic int ref_slew(int t, int d);
    if (d > t) return t + (((d - t) > 256) ? 256 : (d - t));
    return d;
  endfunction

  // Advance one clock and update the reference model.
  task automatic tick();
`ifdef BRAKE_CUT_EN
    logic b;
    b = brake_n;
`endif
    @(posedge clk);
    #1;
    cyc++;
    m_vld = 1'b0;
    if (!rst_n) begin
      dq.delete(); oq.delete(); m_dem = 0; m_tgt = 0;
    end else begin
      if (dq.size() > 0 && dq[0].due == cyc) begin
        m_dem = dq[0].val; void'(dq.pop_front());
      end
      if (oq.size() > 0 && oq[0].due == cyc) begin
        m_vld = 1'b1; m_tgt = ref_slew(m_tgt, oq[0].val); void'(oq.pop_front());
      end
`ifdef BRAKE_CUT_EN
      if (!b) m_tgt = 0;
`endif
    end
  endtask

  task automatic cycle(bit v, int t, int c, int i, int s);
    int d;
    in_vld = v; avg_torque = 12'(t); cadence_vec = 5'(c);
    incline = 13'(i); setting = 2'(s);
    if (v) begin
      d = ref_demand(t, c, i, s);
      dq.push_back('{cyc + 3, d});
      oq.push_back('{cyc + 4, d});
    end
    tick();
  endtask

  task automatic prime();
    for (int k = 0; k < 12; k++) cycle(1'b1, 'h780, 16, 0, 3);
    for (int k = 0; k < 4; k++)  cycle(1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; avg_torque = '0; cadence_vec = '0;
    incline = '0; setting = '0;
`ifdef BRAKE_CUT_EN
    brake_n = 1'b1;
`endif
    for (int k = 0; k < 3; k++) tick();
    checks++; if (demand !== 12'h000)   begin errors++; $display("FAIL reset_demand got=%h exp=000", demand); end
    checks++; if (target_curr !== 12'h000) begin errors++; $display("FAIL reset_target got=%h exp=000", target_curr); end
    checks++; if (out_vld !== 1'b0)     begin errors++; $display("FAIL reset_vld got=%b exp=0", out_vld); end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int pulses = 0;
    int exp_t;
    for (int k = 0; k < 16; k++) begin
      cycle(k < 12, 'h780, 16, 0, 3);
      checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL nom_vld cyc=%0d got=%b exp=%b", cyc, out_vld, m_vld); end
      checks++; if (target_curr !== 12'(m_tgt)) begin errors++; $display("FAIL nom_target cyc=%0d got=%h exp=%h", cyc, target_curr, m_tgt); end
      if (out_vld) begin
        pulses++;
        exp_t = (pulses * 256 > 'h900) ? 'h900 : pulses * 256;
        checks++; if (target_curr !== 12'(exp_t)) begin errors++; $display("FAIL nom_step pulse=%0d got=%h exp=%h", pulses, target_curr, exp_t); end
        checks++; if (demand !== 12'h900) begin errors++; $display("FAIL nom_demand pulse=%0d got=%h exp=900", pulses, demand); end
      end
    end
    checks++; if (pulses != 12) begin errors++; $display("FAIL nom_pulses got=%0d exp=12", pulses); end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    int exp_t;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cycle(k < 20, 'hFFF, 31, 255, 3);
      checks++; if (target_curr !== 12'(m_tgt)) begin errors++; $display("FAIL sat_target cyc=%0d got=%h exp=%h", cyc, target_curr, m_tgt); end
      if (out_vld) begin
        pulses++;
        exp_t = (pulses >= 16) ? 'hFFF : pulses * 256;
        checks++; if (target_curr !== 12'(exp_t)) begin errors++; $display("FAIL sat_step pulse=%0d got=%h exp=%h", pulses, target_curr, exp_t); end
        checks++; if (demand !== 12'hFFF) begin errors++; $display("FAIL sat_demand got=%h exp=fff", demand); end
      end
    end
    checks++; if (pulses != 20) begin errors++; $display("FAIL sat_pulses got=%0d exp=20", pulses); end
  endtask

  task automatic test_zero_paths();
    int tq[4] = '{'h780, 'h780, 'h780, 'h300};
    int cd[4] = '{16, 1, 16, 16};
    int ic[4] = '{-300, 0, 0, 0};
    int st[4] = '{3, 3, 0, 3};
    for (int n = 0; n < 4; n++) begin
      prime();
      checks++; if (target_curr !== 12'h900) begin errors++; $display("FAIL zero_prime case=%0d got=%h exp=900", n, target_curr); end
      cycle(1'b1, tq[n], cd[n], ic[n], st[n]);
      for (int k = 0; k < 4; k++) begin
        cycle(1'b0, 0, 0, 0, 0);
        checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL zero_vld case=%0d got=%b exp=%b", n, out_vld, m_vld); end
        if (k == 2) begin
          checks++; if (out_vld !== 1'b1 || target_curr !== 12'h000 || demand !== 12'h000) begin
            errors++; $display("FAIL zero_result case=%0d vld=%b target=%h demand=%h exp 1/000/000", n, out_vld, target_curr, demand);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int iss[10];
    int p = 0;
    for (int k = 0; k < 18; k++) begin
      if (k < 10) iss[k] = cyc;
      cycle(k < 10, 'h400 + k * 'h50, 16, 0, 3);
      checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL b2b_vld cyc=%0d got=%b exp=%b", cyc, out_vld, m_vld); end
      checks++; if (demand !== 12'(m_dem)) begin errors++; $display("FAIL b2b_demand cyc=%0d got=%h exp=%h", cyc, demand, m_dem); end
      checks++; if (target_curr !== 12'(m_tgt)) begin errors++; $display("FAIL b2b_target cyc=%0d got=%h exp=%h", cyc, target_curr, m_tgt); end
      if (out_vld) begin
        if (p < 10) begin
          checks++; if (cyc != iss[p] + 4) begin errors++; $display("FAIL b2b_latency idx=%0d got=%0d exp=%0d", p, cyc - iss[p], 4); end
        end
        p++;
      end
    end
    checks++; if (p != 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10", p); end
  endtask

  task automatic test_reset_midflight();
    prime();
    cycle(1'b1, 'hFFF, 31, 255, 3);
    cycle(1'b0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (demand !== 12'h000 || target_curr !== 12'h000 || out_vld !== 1'b0) begin
      errors++; $display("FAIL midrst_async demand=%h target=%h vld=%b exp 000/000/0", demand, target_curr, out_vld);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 0, 0, 0, 0);
      checks++; if (out_vld !== 1'b0 || target_curr !== 12'h000 || demand !== 12'h000) begin
        errors++; $display("FAIL midrst_after cyc=%0d vld=%b target=%h demand=%h exp 0/000/000", cyc, out_vld, target_curr, demand);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      cycle(k < 74 && $urandom_range(0, 3) != 0, $urandom_range(0, 4095),
            $urandom_range(0, 31), int'($urandom_range(0, 8191)) - 4096,
            $urandom_range(0, 3));
      checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, out_vld, m_vld); end
      checks++; if (demand !== 12'(m_dem)) begin errors++; $display("FAIL rnd_demand cyc=%0d got=%h exp=%h", cyc, demand, m_dem); end
      checks++; if (target_curr !== 12'(m_tgt)) begin errors++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", cyc, target_curr, m_tgt); end
    end
  endtask

`ifdef BRAKE_CUT_EN
  task automatic test_brake();
    int pulses = 0;
    prime();
    brake_n = 1'b0;
    cycle(1'b1, 'h780, 16, 0, 3);
    for (int k = 0; k < 5; k++) begin
      checks++; if (target_curr !== 12'h000 || demand !== 12'h900) begin
        errors++; $display("FAIL brake_hold k=%0d target=%h demand=%h exp 000/900", k, target_curr, demand);
      end
      checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL brake_vld k=%0d got=%b exp=%b", k, out_vld, m_vld); end
      cycle(1'b0, 0, 0, 0, 0);
    end
    brake_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cycle(k < 3, 'h780, 16, 0, 3);
      if (out_vld) begin
        pulses++;
        checks++; if (target_curr !== 12'(pulses * 256)) begin errors++; $display("FAIL brake_ramp pulse=%0d got=%h exp=%h", pulses, target_curr, pulses * 256); end
      end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL brake_pulses got=%0d exp=3", pulses); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_zero_paths();
    test_back_to_back();
    test_reset_midflight();
    test_random();
`ifdef BRAKE_CUT_EN
    test_brake();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/assist_target_pipe.md
Name: assist_target_pipe

Overview:
- Parametrised successor of the e-bike desired-drive block: converts averaged torque, cadence, incline and assist setting into a motor target current.
- Adds an input/output valid handshake, a fully pipelined datapath and an output slew-rate limiter.
- Sits between the sensor conditioning blocks (torque averager, cadence filter, inclinometer) and the motor current PI loop.

Parameters:
- TORQUE_W, 12, avg_torque width
- INCLINE_W, 13, signed incline width (must be ≥10)
- CAD_W, 5, cadence_vec width
- CURR_W, 12, target_curr width
- TORQUE_MIN, 12'h380, torque deadband offset
- PROD_SHIFT, 14, right-shift applied to the assist product
- SLEW_UP, 12'h100, maximum target increase per output update
- SLEW_DN, 0, maximum decrease per update; 0 means an immediate drop

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  input sample qualifier, one-cycle pulse per sample
- avg_torque  in  TORQUE_W  unsigned averaged torque
- cadence_vec  in  CAD_W  unsigned cadence
- incline  in  INCLINE_W  signed two's-complement incline
- setting  in  2  assist level: 0 off, 1–3 gain
- demand  out  CURR_W  unslewed computed current
- target_curr  out  CURR_W  slewed target current
- out_vld  out  1  one-cycle pulse when target_curr updates

Behaviour:
- Reset (async assert, sync release): all pipeline registers, valid shift chain, demand, target_curr and out_vld are 0.
- Pipeline: four stages, fully pipelined (accepts in_vld every cycle, no stall).
  - out_vld asserts exactly 4 cycles after in_vld.
  - A stage register loads only when its valid bit is set; otherwise it holds.
- S1 (conditioning):
  - torque_pos = max(avg_torque − TORQUE_MIN, 0), computed with a borrow bit, TORQUE_W wide.
  - incline_sat = incline clamped to signed 10-bit [−512, 511].
  - incline_lim = incline_sat + 256, clamped to [0, 511], 9-bit.
  - cad_factor = 0 if cadence_vec ≤ 1, else cadence_vec + 2^CAD_W, width CAD_W+1.
  - setting is registered.
- S2: a1 = torque_pos × setting; a2 = incline_lim × cad_factor. Both are full-width, with no truncation.
- S3:
  - prod = a1 × a2 at full width.
  - demand = all-ones if any bit of prod above PROD_SHIFT+CURR_W−1 is set; otherwise prod[PROD_SHIFT+CURR_W−1:PROD_SHIFT].
  - The demand port updates here.
- S4 (slew), evaluated once per valid:
  - If demand > target_curr: target_curr += min(demand − target_curr, SLEW_UP).
  - If demand < target_curr: with SLEW_DN = 0, target_curr = demand; otherwise target_curr −= min(target_curr − demand, SLEW_DN).
  - Compute the increment with one extra bit so target_curr never wraps past all-ones or below 0.
  - out_vld pulses at this update.
- Boundaries:
  - setting = 0 or cadence ≤ 1 gives demand = 0, so target_curr drops at once (SLEW_DN = 0).
  - When no in_vld arrives, target_curr holds indefinitely.
  - rst_n asserted mid-pipeline discards all in-flight samples; no out_vld pulse results from them.

Optional Feature:
- Macro: BRAKE_CUT_EN.
- When defined:
  - Adds input port brake_n (active low).
  - While brake_n = 0, target_curr is forced to 0 on the next clk edge, regardless of valid; the slew logic is bypassed.
  - out_vld keeps pulsing normally.
  - After release, target_curr ramps up from 0 under SLEW_UP.
- When undefined: no port and no logic; behaviour is as above.

Decomposition:
- Shared package `assist_pkg`:
  - Setting encoding localparams (ASSIST_OFF = 0, LOW, MED, HIGH).
  - Incline clamp bounds (−512, 511, offset 256).
  - Cadence threshold (1).
  - Default TORQUE_MIN.
- Single sub-module `slew_limiter` (params CURR_W, SLEW_UP, SLEW_DN; ports clk, rst_n, vld, demand, target, brake_n under the macro) implements S4.
- Stages S1–S3 stay inline.

Test Plan:
- Nominal ramp: torque 12'h780, setting 3, incline 0, cadence 16, in_vld every cycle, defaults.
  - Required: demand = 12'h900 four cycles after the first in_vld.
  - target_curr steps 0x100, 0x200, … on successive out_vld pulses and reaches 0x900 on the 9th pulse, then holds.
- Saturation: torque 12'hFFF, setting 3, incline 255, cadence 31.
  - Required: demand = 12'hFFF; target_curr reaches 12'hFFF after 16 updates with no wrap.
- Zero paths (start from target 0x900):
  - Incline −300 → demand 0 and target_curr = 0 on the next out_vld.
  - cadence 1 → same result.
  - setting 0 → same result.
  - Torque 12'h300 → torque_pos 0, so demand 0.
- Throughput/latency: 10 back-to-back in_vld with distinct torques.
  - Required: 10 out_vld pulses, each exactly 4 cycles later, in order.
  - Then one idle gap: no spurious out_vld.
- Reset mid-flight: in_vld then rst_n low on cycle 2 for one cycle.
  - Required: all outputs 0 immediately (async); no out_vld follows.
- BRAKE_CUT_EN: at target 0x900, pull brake_n low.
  - Required: target_curr = 0 the next cycle while demand stays 0x900.
  - On release, target ramps to 0x100, 0x200, …
